// File: rtl/ladybird_bus_pkg.sv
// Shared types for the ladybird bus and the wait-state bridge.
//   bus_request_s  : one ladybird bus request (also used by the arbitrator)
//   bridge_state_e : bridge control states
//   DEFAULT_ERR_DATA, TIMEOUT_CNT_W : bridge defaults
package ladybird_bus_pkg;

  typedef struct packed {
    logic        req;
    logic [3:0]  wstrb;   // 0 = read
    logic [31:0] addr;
    logic [31:0] data;
  } bus_request_s;

  typedef enum logic [2:0] {
    IDLE,
    WCMD,
    RCMD,
    RWAIT,
    RGNT
  } bridge_state_e;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Wide enough for TIMEOUT up to 65535.
  localparam int TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/ladybird_bus_wait_bridge_if.sv
// Ladybird bus as seen between the arbitrator (master) and a slave.
//   req/wstrb/addr/wdata : held by the master until gnt
//   gnt                  : request accepted this cycle
//   data_gnt/rdata       : response, one cycle after gnt
interface ladybird_bus_wait_bridge_if;
  logic        req;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        data_gnt;
  logic [31:0] rdata;

  modport master (
    output req, wstrb, addr, wdata,
    input  gnt, data_gnt, rdata
  );

  modport slave (
    input  req, wstrb, addr, wdata,
    output gnt, data_gnt, rdata
  );
endinterface

// File: rtl/ladybird_bus_wait_bridge.sv
// Adapts the fixed-timing ladybird bus to a variable-latency ready/valid
// backend. Writes are posted (granted in IDLE, forwarded afterwards); reads
// hold gnt low until backend data is in hand, then are re-validated against
// the request still on the bus before granting.
// Ports:
//   clk, anrst (async, active-low), nrst (sync, active-low)
//   bus      : ladybird bus slave side
//   b_req/b_wstrb/b_addr/b_wdata/b_ack : backend command handshake
//   b_rvalid/b_rdata                   : backend read data, in order
//   err_o    : one-cycle pulse when a command times out
//   busy     : bridge not idle
module ladybird_bus_wait_bridge
  import ladybird_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic                       clk,
  input  logic                       anrst,
  input  logic                       nrst,
  ladybird_bus_wait_bridge_if.slave  bus,
  output logic                       b_req,
  output logic [3:0]                 b_wstrb,
  output logic [31:0]                b_addr,
  output logic [31:0]                b_wdata,
  input  logic                       b_ack,
  input  logic                       b_rvalid,
  input  logic [31:0]                b_rdata,
  output logic                       err_o,
  output logic                       busy
);

  localparam logic [TIMEOUT_CNT_W-1:0] CNT_LAST = TIMEOUT_CNT_W'(TIMEOUT - 1);

  bridge_state_e             state_q;
  bus_request_s              cmd_q;       // cmd_q.req doubles as b_req
  logic [31:0]               rdata_cap_q; // read data waiting for RGNT
  logic [31:0]               rdata_q;
  logic                      data_gnt_q;
  logic                      err_q;
  logic                      orphan_q;    // one backend response still owed to an aborted read
  logic [TIMEOUT_CNT_W-1:0]  cnt_q;

  logic rst_inactive;
  logic wr_accept;
  logic rd_grant;
  logic timeout;
  logic rvalid_live;

  // NOTE: bus_gnt must be combinational (the master samples it in the same
  // cycle it presents the request); it is a pure function of registered state
  // and inputs, so no latch can form. It is masked during reset so no write
  // is acknowledged that the bridge would then forget.
  assign rst_inactive = anrst & nrst;
  assign wr_accept    = (state_q == IDLE) && bus.req && (bus.wstrb != 4'h0);
  assign rd_grant     = (state_q == RGNT) && bus.req && (bus.wstrb == 4'h0)
                        && (bus.addr == cmd_q.addr);
  assign bus.gnt      = rst_inactive & (wr_accept | rd_grant);

  // Timeout fires on the last allowed cycle; the abort is visible next cycle.
  assign timeout     = (cnt_q == CNT_LAST);
  // A response owed to an aborted read is consumed, never delivered.
  assign rvalid_live = b_rvalid & ~orphan_q;

  // NOTE: every register, data included, is reset so all outputs read 0
  // during and immediately after reset; sequential state uses non-blocking
  // assignments only, so the case branches below may read the old values.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rdata_cap_q <= '0;
      rdata_q     <= '0;
      data_gnt_q  <= 1'b0;
      err_q       <= 1'b0;
      orphan_q    <= 1'b0;
      cnt_q       <= '0;
    end else if (!nrst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rdata_cap_q <= '0;
      rdata_q     <= '0;
      data_gnt_q  <= 1'b0;
      err_q       <= 1'b0;
      orphan_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      data_gnt_q <= bus.gnt;
      err_q      <= 1'b0;

      if (wr_accept) begin
        rdata_q <= '0;
      end else if (rd_grant) begin
        rdata_q <= rdata_cap_q;
      end

      if (orphan_q && b_rvalid) begin
        orphan_q <= 1'b0;
      end

      if (state_q inside {WCMD, RCMD, RWAIT}) begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.req) begin
            cmd_q   <= '{req: 1'b1, wstrb: bus.wstrb, addr: bus.addr, data: bus.wdata};
            cnt_q   <= '0;
            state_q <= (bus.wstrb != 4'h0) ? WCMD : RCMD;
          end
        end

        WCMD: begin
          if (b_ack) begin
            cmd_q.req <= 1'b0;
            state_q   <= IDLE;
          end else if (timeout) begin
            // Already acknowledged on the bus; the write is simply lost.
            cmd_q.req <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= IDLE;
          end
        end

        RCMD: begin
          if (b_ack && rvalid_live) begin
            cmd_q.req   <= 1'b0;
            rdata_cap_q <= b_rdata;
            state_q     <= RGNT;
          end else if (timeout) begin
            // An ack on this very cycle still leaves a response owed.
            cmd_q.req   <= 1'b0;
            err_q       <= 1'b1;
            rdata_cap_q <= ERR_DATA;
            orphan_q    <= b_ack;
            state_q     <= RGNT;
          end else if (b_ack) begin
            cmd_q.req <= 1'b0;
            state_q   <= RWAIT;
          end
        end

        RWAIT: begin
          if (rvalid_live) begin
            rdata_cap_q <= b_rdata;
            state_q     <= RGNT;
          end else if (timeout) begin
            err_q       <= 1'b1;
            rdata_cap_q <= ERR_DATA;
            orphan_q    <= 1'b1;
            state_q     <= RGNT;
          end
        end

        // One-shot: either granted (rd_grant) or the data is dropped and the
        // current request is re-serviced from IDLE.
        RGNT:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign b_req        = cmd_q.req;
  assign b_wstrb      = cmd_q.wstrb;
  assign b_addr       = cmd_q.addr;
  assign b_wdata      = cmd_q.data;
  assign bus.data_gnt = data_gnt_q;
  assign bus.rdata    = rdata_q;
  assign err_o        = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ladybird_bus_wait_bridge.sv
// Directed bench for ladybird_bus_wait_bridge (TIMEOUT = 8). Expected bus
// responses and backend commands are queued when the stimulus is driven and
// popped by a monitor when the DUT produces them.
module tb_ladybird_bus_wait_bridge;

  logic        clk = 1'b0;
  logic        anrst;
  logic        nrst;
  logic        b_req;
  logic [3:0]  b_wstrb;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        err_o;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_rsp[$];
  logic [67:0] exp_cmd[$];

  ladybird_bus_wait_bridge_if bus_if ();

  ladybird_bus_wait_bridge #(
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .anrst    (anrst),
    .nrst     (nrst),
    .bus      (bus_if),
    .b_req    (b_req),
    .b_wstrb  (b_wstrb),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .err_o    (err_o),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic bus_drive(input logic req, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] data);
    bus_if.req   = req;
    bus_if.wstrb = strb;
    bus_if.addr  = addr;
    bus_if.wdata = data;
  endtask

  // Scoreboard side: every response and every accepted backend command
  // must match the oldest expectation.
  always @(negedge clk) begin
    if (bus_if.data_gnt) begin
      if (exp_rsp.size() == 0) check("rsp_extra", 72'(bus_if.data_gnt), 72'(0));
      else check("rsp_rdata", 72'(bus_if.rdata), 72'(exp_rsp.pop_front()));
    end
    if (b_req && b_ack) begin
      if (exp_cmd.size() == 0) check("cmd_extra", 72'(b_req), 72'(0));
      else check("cmd_fields", 72'({b_wstrb, b_addr, b_wdata}), 72'(exp_cmd.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    anrst    = 1'b0;
    nrst     = 1'b1;
    b_ack    = 1'b0;
    b_rvalid = 1'b0;
    b_rdata  = '0;
    bus_drive(1'b0, 4'h0, 32'h0, 32'h0);

    // Reset state
    repeat (2) tick();
    sample();
    check("rst_ctrl", 72'({bus_if.gnt, bus_if.data_gnt, b_req, err_o, busy}), 72'(0));
    check("rst_data", 72'({bus_if.rdata, b_addr}), 72'(0));
    tick();
    anrst = 1'b1;

    // Posted write, backend ack on the third command cycle
    tick();
    bus_drive(1'b1, 4'hF, 32'h100, 32'h1234_5678);
    exp_rsp.push_back(32'h0);
    exp_cmd.push_back({4'hF, 32'h100, 32'h1234_5678});
    sample();
    check("wr_gnt", 72'(bus_if.gnt), 72'(1));
    check("wr_busy_idle", 72'(busy), 72'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) bus_drive(1'b0, 4'h0, 32'h0, 32'h0);
      b_ack = (i == 2);
      sample();
      check("wr_b_req", 72'(b_req), 72'(1));
      check("wr_no_gnt", 72'({bus_if.gnt, err_o}), 72'(0));
    end
    tick();
    b_ack = 1'b0;
    sample();
    check("wr_done", 72'({b_req, busy}), 72'(0));

    // Read, immediate ack, data five cycles later
    tick();
    bus_drive(1'b1, 4'h0, 32'h200, 32'h0);
    exp_cmd.push_back({4'h0, 32'h200, 32'h0});
    exp_rsp.push_back(32'hCAFE_F00D);
    sample();
    check("rd_idle_no_gnt", 72'(bus_if.gnt), 72'(0));
    tick();
    b_ack = 1'b1;
    sample();
    check("rd_rcmd_b_req", 72'(b_req), 72'(1));
    for (int i = 1; i <= 5; i++) begin
      tick();
      b_ack    = 1'b0;
      b_rvalid = (i == 5);
      b_rdata  = (i == 5) ? 32'hCAFE_F00D : 32'h0;
      sample();
      check("rd_wait_no_gnt", 72'({bus_if.gnt, b_req}), 72'(0));
    end
    tick();
    b_rvalid = 1'b0;
    sample();
    check("rd_rgnt_gnt", 72'(bus_if.gnt), 72'(1));
    tick();
    bus_drive(1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    check("rd_after_no_gnt", 72'(bus_if.gnt), 72'(0));

    // Master switches address while the read is outstanding
    tick();
    bus_drive(1'b1, 4'h0, 32'h200, 32'h0);
    exp_cmd.push_back({4'h0, 32'h200, 32'h0});
    tick();
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    bus_drive(1'b1, 4'h0, 32'h300, 32'h0);
    exp_cmd.push_back({4'h0, 32'h300, 32'h0});
    exp_rsp.push_back(32'h3333_0300);
    tick();
    b_rvalid = 1'b1;
    b_rdata  = 32'h2222_0200;
    tick();
    b_rvalid = 1'b0;
    sample();
    check("sw_rgnt_no_gnt", 72'(bus_if.gnt), 72'(0));
    tick();
    sample();
    check("sw_discarded", 72'({bus_if.gnt, bus_if.data_gnt}), 72'(0));
    tick();
    b_ack    = 1'b1;
    b_rvalid = 1'b1;
    b_rdata  = 32'h3333_0300;
    sample();
    check("sw_reissue_addr", 72'(b_addr), 72'(32'h300));
    tick();
    b_ack    = 1'b0;
    b_rvalid = 1'b0;
    sample();
    check("sw_gnt", 72'(bus_if.gnt), 72'(1));
    tick();
    bus_drive(1'b0, 4'h0, 32'h0, 32'h0);
    sample();

    // Read timeout after ack, late response dropped, next read correct
    tick();
    bus_drive(1'b1, 4'h0, 32'h400, 32'h0);
    exp_cmd.push_back({4'h0, 32'h400, 32'h0});
    exp_rsp.push_back(32'hDEAD_BEEF);
    tick();
    b_ack = 1'b1;
    sample();
    check("to_rd_no_err0", 72'(err_o), 72'(0));
    for (int i = 1; i <= 7; i++) begin
      tick();
      b_ack = 1'b0;
      sample();
      check("to_rd_no_err", 72'({err_o, busy}), 72'(1));
    end
    tick();
    sample();
    check("to_rd_err", 72'(err_o), 72'(1));
    check("to_rd_gnt", 72'(bus_if.gnt), 72'(1));
    tick();
    bus_drive(1'b1, 4'h0, 32'h500, 32'h0);
    exp_cmd.push_back({4'h0, 32'h500, 32'h0});
    exp_rsp.push_back(32'h5555_5555);
    sample();
    check("to_rd_err_pulse", 72'(err_o), 72'(0));
    tick();
    b_ack    = 1'b1;
    b_rvalid = 1'b1;
    b_rdata  = 32'h1111_1111;
    tick();
    b_ack   = 1'b0;
    b_rdata = 32'h5555_5555;
    tick();
    b_rvalid = 1'b0;
    sample();
    check("orphan_next_gnt", 72'(bus_if.gnt), 72'(1));
    tick();
    bus_drive(1'b0, 4'h0, 32'h0, 32'h0);
    sample();

    // Asynchronous reset while waiting for read data
    tick();
    bus_drive(1'b1, 4'h0, 32'h800, 32'h0);
    exp_cmd.push_back({4'h0, 32'h800, 32'h0});
    tick();
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    sample();
    check("arst_pre_busy", 72'(busy), 72'(1));
    #1 anrst = 1'b0;
    #1;
    check("arst_ctrl", 72'({bus_if.gnt, bus_if.data_gnt, b_req, err_o, busy}), 72'(0));
    check("arst_data", 72'({bus_if.rdata, b_addr}), 72'(0));
    tick();
    anrst = 1'b1;
    bus_drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    bus_drive(1'b1, 4'h0, 32'h900, 32'h0);
    exp_cmd.push_back({4'h0, 32'h900, 32'h0});
    exp_rsp.push_back(32'h9999_9999);
    tick();
    b_ack = 1'b1;
    tick();
    b_ack    = 1'b0;
    b_rvalid = 1'b1;
    b_rdata  = 32'h9999_9999;
    tick();
    b_rvalid = 1'b0;
    sample();
    check("arst_next_gnt", 72'(bus_if.gnt), 72'(1));
    tick();
    bus_drive(1'b0, 4'h0, 32'h0, 32'h0);
    sample();

    // Write never acked by the backend
    tick();
    bus_drive(1'b1, 4'h3, 32'h600, 32'hA5A5_A5A5);
    exp_rsp.push_back(32'h0);
    sample();
    check("to_wr_gnt", 72'(bus_if.gnt), 72'(1));
    tick();
    bus_drive(1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    check("to_wr_no_err0", 72'(err_o), 72'(0));
    for (int i = 1; i <= 7; i++) begin
      tick();
      sample();
      check("to_wr_waiting", 72'({b_req, err_o}), 72'(2));
    end
    tick();
    bus_drive(1'b1, 4'h1, 32'h700, 32'h0000_005A);
    exp_rsp.push_back(32'h0);
    exp_cmd.push_back({4'h1, 32'h700, 32'h0000_005A});
    sample();
    check("to_wr_err", 72'({err_o, busy, b_req}), 72'(4));
    check("to_wr_next_gnt", 72'(bus_if.gnt), 72'(1));
    tick();
    bus_drive(1'b0, 4'h0, 32'h0, 32'h0);
    b_ack = 1'b1;
    sample();
    check("to_wr_next_b_req", 72'(b_req), 72'(1));
    tick();
    b_ack = 1'b0;
    sample();
    check("to_wr_next_done", 72'({busy, err_o}), 72'(0));

    // Synchronous reset takes effect on the next edge
    tick();
    bus_drive(1'b1, 4'h0, 32'hA00, 32'h0);
    tick();
    bus_drive(1'b0, 4'h0, 32'h0, 32'h0);
    nrst = 1'b0;
    sample();
    check("srst_pre", 72'({busy, b_req}), 72'(3));
    tick();
    sample();
    check("srst_post", 72'({busy, b_req, b_addr}), 72'(0));
    nrst = 1'b1;

    tick();
    check("rsp_queue_drained", 72'(exp_rsp.size()), 72'(0));
    check("cmd_queue_drained", 72'(exp_cmd.size()), 72'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
